// File: rtl/aes_ctr_incr_fsm.sv
// aes_ctr_incr_fsm: slice-serial counter incrementer for AES CTR/GCM.
//
// Adds a programmable step to a wide counter held in an external register
// file, one slice per cycle, LSB slice first. mode_i=0 increments the full
// counter; mode_i=1 is GCM inc32, where only the low 32 bits are touched and
// the carry out of bit 31 is reported on wrap_o.
//
// Ports:
//   clk_i            clock
//   rst_i            synchronous active-high reset
//   incr_i           increment request, accepted while ready_o=1
//   step_i           increment amount, added to slice 0 only
//   mode_i           0: full-width increment, 1: inc32
//   ready_o          idle and able to accept a request
//   incr_err_i       multi-rail encoding error on incr_i
//   mr_err_i         multi-rail error from the upstream controller
//   alert_o          FSM is in, or entering, the error state
//   ctr_slice_idx_o  index of the slice being read/written
//   ctr_slice_i      current value of the addressed slice
//   ctr_slice_o      updated value of the addressed slice (valid with ctr_we_o)
//   ctr_we_o         write enable for ctr_slice_o
//   done_o           one-cycle pulse after the final slice write
//   wrap_o           carry out of the last processed slice
//
// Build option: define AES_CTR_EARLY_EXIT_EN to stop as soon as the carry
// dies out (data-dependent latency, non-secret counters only). Without it
// every request takes a fixed number of write cycles.

module aes_ctr_incr_fsm #(
    parameter int unsigned CtrWidth  = 128,
    parameter int unsigned SliceSize = 16,
    localparam int unsigned NumSlices = CtrWidth / SliceSize,
    localparam int unsigned SliceIdxW = (NumSlices > 1) ? $clog2(NumSlices) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 incr_i,
    input  logic [SliceSize-1:0] step_i,
    input  logic                 mode_i,
    output logic                 ready_o,
    input  logic                 incr_err_i,
    input  logic                 mr_err_i,
    output logic                 alert_o,
    output logic [SliceIdxW-1:0] ctr_slice_idx_o,
    input  logic [SliceSize-1:0] ctr_slice_i,
    output logic [SliceSize-1:0] ctr_slice_o,
    output logic                 ctr_we_o,
    output logic                 done_o,
    output logic                 wrap_o
);

    // Elaboration-time parameter sanity checks.
    if ((CtrWidth % SliceSize) != 0) begin : gen_err_ctr_width
        $error("CtrWidth must be a multiple of SliceSize");
    end
    if ((32 % SliceSize) != 0) begin : gen_err_slice_size
        $error("SliceSize must divide 32");
    end
    if (CtrWidth < 32) begin : gen_err_ctr_min
        $error("CtrWidth must be at least 32");
    end

    localparam logic [SliceIdxW-1:0] LastFull  = SliceIdxW'(NumSlices - 1);
    localparam logic [SliceIdxW-1:0] LastInc32 = SliceIdxW'(32 / SliceSize - 1);

    // Sparse encoding: pairwise Hamming distance >= 3, so a single upset cannot
    // turn one valid state into another; any other value is trapped to StError.
    typedef enum logic [5:0] {
        StIdle  = 6'b011101,
        StIncr  = 6'b100011,
        StError = 6'b111110
    } state_e;

    state_e                 state_q, state_d;
    logic [SliceIdxW-1:0]   idx_q, idx_d;
    logic                   carry_q, carry_d;
    logic [SliceSize-1:0]   step_q, step_d;
    logic                   mode_q, mode_d;
    logic                   done_q, done_d;
    logic                   wrap_q, wrap_d;

    logic                   err_in;
    logic [SliceIdxW-1:0]   last_idx;
    logic                   last_slice;
    logic                   finish;
    logic [SliceSize-1:0]   addend;
    logic [SliceSize:0]     sum;
    logic                   ready;
    logic                   we;

    assign err_in     = incr_err_i | mr_err_i;
    assign last_idx   = mode_q ? LastInc32 : LastFull;
    assign last_slice = (idx_q == last_idx);

    // The step only enters slice 0; higher slices only propagate the carry.
    assign addend = (idx_q == '0) ? step_q : SliceSize'(carry_q);
    assign sum    = {1'b0, ctr_slice_i} + {1'b0, addend};

`ifdef AES_CTR_EARLY_EXIT_EN
    // Once the carry dies out the higher slices cannot change.
    assign finish = last_slice | ~sum[SliceSize];
`else
    assign finish = last_slice;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        step_d  = step_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        wrap_d  = wrap_q;
        ready   = 1'b0;
        we      = 1'b0;

        case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (incr_i) begin
                    step_d  = step_i;
                    mode_d  = mode_i;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    wrap_d  = 1'b0;
                    state_d = StIncr;
                end
            end
            StIncr: begin
                we      = 1'b1;
                carry_d = sum[SliceSize];
                idx_d   = idx_q + SliceIdxW'(1);
                if (finish) begin
                    // On an early exit the final carry is 0 by construction.
                    state_d = StIdle;
                    idx_d   = '0;
                    done_d  = 1'b1;
                    wrap_d  = sum[SliceSize];
                end
            end
            StError: begin
                state_d = StError;
            end
            default: begin
                state_d = StError;
            end
        endcase

        // Error inputs override everything, including a same-cycle request.
        if (err_in) begin
            state_d = StError;
            idx_d   = idx_q;
            carry_d = carry_q;
            step_d  = step_q;
            mode_d  = mode_q;
            done_d  = 1'b0;
            wrap_d  = wrap_q;
            ready   = 1'b0;
            we      = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            step_q  <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign ready_o         = ready;
    assign ctr_we_o        = we;
    assign ctr_slice_idx_o = idx_q;
    assign ctr_slice_o     = sum[SliceSize-1:0];
    assign done_o          = done_q;
    assign wrap_o          = wrap_q;
    assign alert_o         = (state_q == StError) || (state_d == StError);

    ast_valid_state: assert property (@(posedge clk_i) disable iff (rst_i)
        !alert_o |-> (state_q == StIdle || state_q == StIncr));

endmodule

// File: tb/tb_aes_ctr_incr_fsm.sv
// Bench for aes_ctr_incr_fsm with CtrWidth=128, SliceSize=16. The bench owns
// the counter register file, predicts each request with plain 128-bit
// arithmetic and checks the DUT every cycle; directed tests pin latency, final
// counter and wrap with literal values.

module tb_aes_ctr_incr_fsm;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         incr_i = 1'b0;
    logic [15:0]  step_i = '0;
    logic         mode_i = 1'b0;
    logic         incr_err_i = 1'b0;
    logic         mr_err_i = 1'b0;
    logic         ready_o;
    logic         alert_o;
    logic [2:0]   ctr_slice_idx_o;
    logic [15:0]  ctr_slice_i;
    logic [15:0]  ctr_slice_o;
    logic         ctr_we_o;
    logic         done_o;
    logic         wrap_o;

    aes_ctr_incr_fsm #(
        .CtrWidth  (128),
        .SliceSize (16)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .incr_i          (incr_i),
        .step_i          (step_i),
        .mode_i          (mode_i),
        .ready_o         (ready_o),
        .incr_err_i      (incr_err_i),
        .mr_err_i        (mr_err_i),
        .alert_o         (alert_o),
        .ctr_slice_idx_o (ctr_slice_idx_o),
        .ctr_slice_i     (ctr_slice_i),
        .ctr_slice_o     (ctr_slice_o),
        .ctr_we_o        (ctr_we_o),
        .done_o          (done_o),
        .wrap_o          (wrap_o)
    );

    always #5 clk_i = ~clk_i;

    // External counter register file.
    logic [127:0] ctr_reg;
    logic         load_en = 1'b0;
    logic [127:0] load_val = '0;

    assign ctr_slice_i = ctr_reg[int'(ctr_slice_idx_o) * 16 +: 16];

    always @(posedge clk_i) begin
        if (load_en) ctr_reg <= load_val;
        else if (ctr_we_o) ctr_reg[int'(ctr_slice_idx_o) * 16 +: 16] <= ctr_slice_o;
    end

    // Model state.
    typedef struct packed {
        logic [2:0]  idx;
        logic [15:0] data;
    } wr_t;

    wr_t  exp_q[$];
    logic model_err = 1'b0;
    logic done_pend = 1'b0;
    logic exp_wrap  = 1'b0;
    logic txn_wrap  = 1'b0;

    logic       snap_done, snap_ready, snap_wrap, snap_alert, snap_we;
    logic [2:0] snap_idx;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Predict the write sequence and wrap of one request from the counter value
    // at acceptance.
    task automatic model_accept(input logic [127:0] old, input logic [15:0] step,
                                input logic mode);
        logic [128:0] full;
        logic [32:0]  s32;
        logic [127:0] nv;
        logic         w;
        int           l;
        if (!mode) begin
            full = {1'b0, old} + 129'(step);
            nv   = full[127:0];
            w    = full[128];
            l    = 8;
        end else begin
            s32 = {1'b0, old[31:0]} + 33'(step);
            nv  = {old[127:32], s32[31:0]};
            w   = s32[32];
            l   = 2;
        end
`ifdef AES_CTR_EARLY_EXIT_EN
        for (int i = 0; i < l - 1; i++) begin
            logic [128:0] part;
            int           k;
            k    = (i + 1) * 16;
            part = ({1'b0, old} & ((129'd1 << k) - 129'd1)) + 129'(step);
            if (!part[k]) begin
                l = i + 1;
                w = 1'b0;
                break;
            end
        end
`endif
        for (int i = 0; i < l; i++) begin
            exp_q.push_back('{idx: 3'(i), data: nv[i * 16 +: 16]});
        end
        txn_wrap = w;
    endtask

    // Per-cycle comparison against the model, sampled at the falling edge.
    task automatic compare();
        logic exp_ready;
        logic exp_we;
        logic exp_done;
        wr_t  front;
        snap_done  = done_o;
        snap_ready = ready_o;
        snap_wrap  = wrap_o;
        snap_alert = alert_o;
        snap_we    = ctr_we_o;
        snap_idx   = ctr_slice_idx_o;
        if (rst_i) begin
            exp_q.delete();
            model_err = 1'b0;
            done_pend = 1'b0;
            exp_wrap  = 1'b0;
            return;
        end
        exp_done  = done_pend;
        done_pend = 1'b0;
        if (exp_done) exp_wrap = txn_wrap;
        if (incr_err_i || mr_err_i) begin
            model_err = 1'b1;
            exp_q.delete();
        end
        exp_ready = !model_err && (exp_q.size() == 0);
        exp_we    = !model_err && (exp_q.size() != 0);
        chk("ready_o", 128'(ready_o), 128'(exp_ready));
        chk("alert_o", 128'(alert_o), 128'(model_err));
        chk("done_o", 128'(done_o), 128'(exp_done));
        chk("wrap_o", 128'(wrap_o), 128'(exp_wrap));
        chk("ctr_we_o", 128'(ctr_we_o), 128'(exp_we));
        if (ctr_we_o && exp_we) begin
            front = exp_q.pop_front();
            chk("slice_idx", 128'(ctr_slice_idx_o), 128'(front.idx));
            chk("slice_data", 128'(ctr_slice_o), 128'(front.data));
            if (exp_q.size() == 0) done_pend = 1'b1;
        end
        if (incr_i && exp_ready) begin
            model_accept(ctr_reg, step_i, mode_i);
            exp_wrap = 1'b0;
        end
    endtask

    // One clock: compare at the falling edge, return just after the rising
    // edge so the caller can drive the next cycle's inputs.
    task automatic cycle();
        @(negedge clk_i);
        compare();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_ctr(input logic [127:0] v);
        load_en  = 1'b1;
        load_val = v;
        cycle();
        load_en  = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        cycle();
        chk("rst_ready", 128'(snap_ready), 128'(1));
        chk("rst_alert", 128'(snap_alert), 128'(0));
        chk("rst_done", 128'(snap_done), 128'(0));
        chk("rst_wrap", 128'(snap_wrap), 128'(0));
    endtask

    // Issue one request and check latency (cycles from acceptance edge to
    // done_o), final counter and wrap against hand-computed values.
    task automatic run(input string name, input logic [127:0] init, input logic [15:0] step,
                       input logic mode, input int lat, input logic [127:0] exp_ctr,
                       input logic exp_w);
        int n;
        load_ctr(init);
        incr_i = 1'b1;
        step_i = step;
        mode_i = mode;
        cycle();
        incr_i = 1'b0;
        step_i = '0;
        mode_i = 1'b0;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!snap_done && n < 40);
        chk({name, "_latency"}, 128'(n), 128'(lat));
        chk({name, "_ready"}, 128'(snap_ready), 128'(1));
        chk({name, "_wrap"}, 128'(snap_wrap), 128'(exp_w));
        chk({name, "_ctr"}, ctr_reg, exp_ctr);
    endtask

    localparam logic [127:0] CtrT2   = 128'h0000_0000_0000_0000_0000_0001_FFFF_FFFF;
    localparam logic [127:0] CtrOnes = {128{1'b1}};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        @(posedge clk_i);
        #1;
        cycle();
        rst_i = 1'b0;
        cycle();
        chk("reset_ready", 128'(snap_ready), 128'(1));
        chk("reset_alert", 128'(snap_alert), 128'(0));
        chk("reset_done", 128'(snap_done), 128'(0));
        chk("reset_wrap", 128'(snap_wrap), 128'(0));
        chk("reset_we", 128'(snap_we), 128'(0));

`ifdef AES_CTR_EARLY_EXIT_EN
        run("t6_early", 128'h0, 16'h0005, 1'b0, 2, 128'h5, 1'b0);
        run("t2_early", CtrT2, 16'h0001, 1'b0, 4,
            128'h0000_0000_0000_0000_0000_0002_0000_0000, 1'b0);
        run("t3_early", CtrT2, 16'h0001, 1'b1, 3,
            128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b1);
        run("t4_early", CtrOnes, 16'h0003, 1'b0, 9, 128'h2, 1'b1);
        run("step0_early", 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 16'h0000, 1'b1, 2,
            128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0);
`else
        run("t1", 128'h0, 16'h0001, 1'b0, 9, 128'h1, 1'b0);
        run("t2", CtrT2, 16'h0001, 1'b0, 9,
            128'h0000_0000_0000_0000_0000_0002_0000_0000, 1'b0);
        run("t3", CtrT2, 16'h0001, 1'b1, 3,
            128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b1);
        run("t4", CtrOnes, 16'h0003, 1'b0, 9, 128'h2, 1'b1);
        run("step0", 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 16'h0000, 1'b1, 3,
            128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0);
        run("inc32_wrap", 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_FFFF_FFF0, 16'h0020, 1'b1, 3,
            128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_0000_0010, 1'b1);

        // mr_err_i while slice 3 is being written.
        load_ctr(128'h0);
        incr_i = 1'b1;
        step_i = 16'h0001;
        cycle();
        incr_i = 1'b0;
        step_i = '0;
        repeat (3) cycle();
        mr_err_i = 1'b1;
        cycle();
        mr_err_i = 1'b0;
        chk("t5_err_idx", 128'(snap_idx), 128'(3));
        chk("t5_err_we", 128'(snap_we), 128'(0));
        chk("t5_err_alert", 128'(snap_alert), 128'(1));
        incr_i = 1'b1;
        step_i = 16'h0001;
        repeat (3) begin
            cycle();
            chk("t5_hold_alert", 128'(snap_alert), 128'(1));
            chk("t5_hold_ready", 128'(snap_ready), 128'(0));
            chk("t5_hold_we", 128'(snap_we), 128'(0));
        end
        incr_i = 1'b0;
        step_i = '0;
        chk("t5_ctr", ctr_reg, 128'h1);
        do_reset();
`endif

        // Request together with incr_err_i in idle: dropped, FSM traps.
        load_ctr(128'h55);
        incr_i     = 1'b1;
        step_i     = 16'h0001;
        incr_err_i = 1'b1;
        cycle();
        chk("t7_alert_now", 128'(snap_alert), 128'(1));
        chk("t7_ready_now", 128'(snap_ready), 128'(0));
        incr_i     = 1'b0;
        step_i     = '0;
        incr_err_i = 1'b0;
        cycle();
        chk("t7_alert_after", 128'(snap_alert), 128'(1));
        chk("t7_we_after", 128'(snap_we), 128'(0));
        chk("t7_ctr", ctr_reg, 128'h55);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_ctr_incr_fsm.md
Name: aes_ctr_incr_fsm

Overview:
Parametrised slice-serial counter incrementer for AES CTR/GCM modes. It adds a programmable step to a wide counter held in an external register file, one slice per cycle, LSB slice first. It supports full-width increment and GCM-style inc32, where only the low 32 bits wrap. It sits between the AES control FSM and the IV/counter register slices.

Parameters:
CtrWidth, 128, total counter width in bits; must be a multiple of SliceSize.
SliceSize, 16, bits processed per cycle; must divide 32.
NumSlices, CtrWidth/SliceSize, derived; number of slices.
SliceIdxW, $clog2(NumSlices), derived; slice index width.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
incr_i  in  1  increment request; accepted only when ready_o=1
step_i  in  SliceSize  increment amount; added to slice 0 only
mode_i  in  1  0 = full-width increment, 1 = inc32 (low 32 bits only)
ready_o  out  1  FSM idle and able to accept a request
incr_err_i  in  1  multi-rail encoding error on incr_i
mr_err_i  in  1  multi-rail error from the upstream controller
alert_o  out  1  FSM is in, or entering, the error state
ctr_slice_idx_o  out  SliceIdxW  index of the slice being read/written
ctr_slice_i  in  SliceSize  current value of the addressed slice
ctr_slice_o  out  SliceSize  updated value of the addressed slice
ctr_we_o  out  1  write enable for ctr_slice_o
done_o  out  1  one-cycle pulse after the final slice write
wrap_o  out  1  carry out of the last processed slice (counter wrapped)

Behaviour:
- Reset (rst_i=1 at a clock edge) applies from any state, including mid-operation:
  - state=IDLE, index=0, carry=0, captured step/mode cleared.
  - done_o=0, wrap_o=0, alert_o=0, ctr_we_o=0; ready_o=1 in the cycle after reset.
- State register is sparse-encoded; all unused encodings go to ERROR with alert_o=1.
- IDLE:
  - ready_o=1.
  - On incr_i=1: capture step_i and mode_i, set index=0, set last index (NumSlices-1 when mode=0, 32/SliceSize-1 when mode=1), clear wrap_o, go to INCR.
- INCR:
  - ready_o=0, ctr_we_o=1.
  - addend = captured step when index=0, else zero-extended carry.
  - sum = ctr_slice_i + addend, computed SliceSize+1 bits wide.
  - ctr_slice_o = sum[SliceSize-1:0]; next carry = sum[SliceSize].
  - Index increments by 1 each cycle.
  - When index == last index: go to IDLE; register done_o=1 and wrap_o=final carry.
- Timing: request accepted at cycle T; writes occur at T+1..T+L (L = last index+1); done_o and ready_o are high at T+L+1.
- ctr_slice_o is combinational from ctr_slice_i. It is only meaningful while ctr_we_o=1.
- wrap_o holds its value until the next accepted request.
- inc32 mode: slices above the last index are never addressed or written; the carry out of bit 31 is discarded into wrap_o.
- step_i=0: all L slices are still written with their unchanged values (constant time).
- ERROR:
  - Terminal; alert_o=1, ready_o=0, ctr_we_o=0, incr_i ignored.
  - Exits only via rst_i.
- Error inputs (incr_err_i or mr_err_i = 1) in any state:
  - Next state is ERROR.
  - ctr_we_o is forced to 0 in that same cycle.
  - done_o is not raised.
- Simultaneous incr_i and error input in IDLE: the request is dropped and the FSM goes to ERROR.
- Assertion: when alert_o=0, state must be IDLE or INCR.
- Parameter checks at elaboration: CtrWidth % SliceSize == 0, 32 % SliceSize == 0, CtrWidth >= 32.

Optional Feature:
AES_CTR_EARLY_EXIT_EN
- Defined: in INCR, if the next carry is 0 and the index is not the last index, the FSM goes to IDLE after the current write.
  - done_o fires the next cycle with wrap_o=0.
  - Higher slices are not written.
  - Data-dependent latency; for non-secret counters only.
- Undefined: fixed latency of L write cycles regardless of carry (the default, constant-time behaviour).

Test Plan:
All scenarios use CtrWidth=128, SliceSize=16, feature undefined unless noted.
1. Counter=0, step=1, mode=0 -> writes idx0=0x0001, idx1..7=0x0000 over 8 cycles; done_o at T+9; wrap_o=0; counter=1.
2. Counter=0x...0001_FFFF_FFFF, step=1, mode=0 -> idx0=0x0000, idx1=0x0000, idx2=0x0002, rest unchanged; wrap_o=0.
3. Same counter, mode=1 -> only idx0 and idx1 written (0x0000, 0x0000); done_o at T+3; wrap_o=1; upper 96 bits untouched.
4. Counter=all-ones, step=3, mode=0 -> idx0=0x0002, idx1..7=0x0000; wrap_o=1.
5. mr_err_i pulsed while index=3 -> ctr_we_o=0 that cycle; alert_o=1 from then on; ready_o=0; incr_i ignored; rst_i -> IDLE, ready_o=1, alert_o=0.
6. With AES_CTR_EARLY_EXIT_EN: counter=0, step=5 -> single write idx0=0x0005; done_o at T+2; ready_o at T+2.
